// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the VeriRISC CPU (port A) and the loader/debug port (port B)
// share one single-port synchronous memory.
// Each granted request runs a fixed 3-cycle transaction: IDLE (arbitrate and
// capture), ACCESS (memory strobe), RESP (ack and read data back to the owner).
// When both ports request in the same IDLE cycle, the port that did not own the
// previous transaction wins.
//
// Ports:
//   clk                    clock, rising edge
//   reset                  asynchronous, active-low reset
//   i_req_a / i_req_b      request, held by the requester until it sees ack
//   i_we_a / i_we_b        1 = write, 0 = read
//   i_addr_a / i_addr_b    memory address
//   i_wdata_a / i_wdata_b  write data
//   o_ack_a / o_ack_b      one-cycle transaction-complete pulse (RESP)
//   o_rdata_a / o_rdata_b  read data, valid while the matching ack is 1
//   o_stall_a              i_req_a & ~o_ack_a, used as the CPU clock-enable
//   o_busy                 transaction in progress (state is not IDLE)
//   o_mem_en / o_mem_wr    memory access and write strobes
//   o_mem_addr             memory address
//   o_mem_wdata            memory write data
//   i_mem_rdata            memory read data, valid the cycle after a read strobe
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_a,
  input  logic              i_we_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_wdata_a,
  output logic              o_ack_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic              i_req_b,
  input  logic              i_we_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wdata_b,
  output logic              o_ack_b,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic              o_stall_a,
  output logic              o_busy,
  output logic              o_mem_en,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  state_t              r_state;
  state_t              w_next_state;

  logic                r_owner;
  logic                r_last_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_any_req;
  logic                w_grant_b;

  assign w_any_req = i_req_a | i_req_b;

  // B wins when it is alone, or when both request and A owned the last
  // transaction. Every other requesting case goes to A.
  assign w_grant_b = i_req_b & (~i_req_a | (r_last_owner == OWNER_A));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The owner and request fields are captured only on the grant edge. Input
  // changes after that edge do not affect the transaction in flight.
  // last_owner resets to B so that A wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= OWNER_A;
      r_last_owner <= OWNER_B;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if ((r_state == IDLE) && w_any_req) begin
      r_owner      <= w_grant_b;
      r_last_owner <= w_grant_b;
      if (w_grant_b) begin
        r_we    <= i_we_b;
        r_addr  <= i_addr_b;
        r_wdata <= i_wdata_b;
      end else begin
        r_we    <= i_we_a;
        r_addr  <= i_addr_a;
        r_wdata <= i_wdata_a;
      end
    end
  end

  // Read data goes straight from the memory to the owner during RESP. The
  // memory presents it the cycle after the ACCESS strobe, so no holding
  // register is needed.
  always_comb begin
    w_next_state = r_state;
    o_ack_a      = 1'b0;
    o_ack_b      = 1'b0;
    o_rdata_a    = '0;
    o_rdata_b    = '0;
    o_mem_en     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        o_mem_en     = 1'b1;
        o_mem_wr     = r_we;
        o_mem_addr   = r_addr;
        o_mem_wdata  = r_wdata;
        w_next_state = RESP;
      end
      RESP: begin
        if (r_owner == OWNER_B) begin
          o_ack_b = 1'b1;
          if (!r_we) begin
            o_rdata_b = i_mem_rdata;
          end
        end else begin
          o_ack_a = 1'b1;
          if (!r_we) begin
            o_rdata_a = i_mem_rdata;
          end
        end
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign o_busy    = (r_state != IDLE);
  assign o_stall_a = i_req_a & ~o_ack_a;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// It contains a behavioural memory that is wired to the arbiter's memory port.
// Test sequence:
//   - a per-cycle vector table covering single reads and writes,
//   - hand-written multi-cycle corner cases: contention, a late request,
//     a reset abort and an input change after capture,
//   - a randomized two-requester run checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqA, weA, reqB, weB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] wdataA, wdataB;
  logic          ackA, ackB, stallA, busy, memEn, memWr;
  logic [DW-1:0] rdataA, rdataB, memWdata, memRdata;
  logic [AW-1:0] memAddr;

  logic [DW-1:0] benchMem [0:31];
  logic [DW-1:0] goldMem  [0:31];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          ackA;
    logic [DW-1:0] rdataA;
    logic          ackB;
    logic [DW-1:0] rdataB;
    logic          stallA;
    logic          busy;
    logic          memEn;
    logic          memWr;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
  } outs_t;

  typedef struct {
    logic          reqA;
    logic          weA;
    logic [AW-1:0] addrA;
    logic [DW-1:0] wdataA;
    logic          reqB;
    logic          weB;
    logic [AW-1:0] addrB;
    logic [DW-1:0] wdataB;
    outs_t         exp;
  } vec_t;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_a     (reqA),
    .i_we_a      (weA),
    .i_addr_a    (addrA),
    .i_wdata_a   (wdataA),
    .o_ack_a     (ackA),
    .o_rdata_a   (rdataA),
    .i_req_b     (reqB),
    .i_we_b      (weB),
    .i_addr_b    (addrB),
    .i_wdata_b   (wdataB),
    .o_ack_b     (ackB),
    .o_rdata_b   (rdataB),
    .o_stall_a   (stallA),
    .o_busy      (busy),
    .o_mem_en    (memEn),
    .o_mem_wr    (memWr),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .i_mem_rdata (memRdata)
  );

  // Single-port synchronous memory: a read strobe returns data on the next cycle.
  always @(posedge clk) begin
    if (memEn) begin
      if (memWr) benchMem[memAddr] <= memWdata;
      else       memRdata <= benchMem[memAddr];
    end
  end

  function automatic logic [DW-1:0] initVal(input int i);
    return DW'(i * 37 + 11);
  endfunction

  function automatic outs_t mkOuts(input logic aA, input logic [DW-1:0] rA,
                                   input logic aB, input logic [DW-1:0] rB,
                                   input logic st, input logic bz,
                                   input logic en, input logic wr,
                                   input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    outs_t o;
    o.ackA = aA; o.rdataA = rA; o.ackB = aB; o.rdataB = rB;
    o.stallA = st; o.busy = bz; o.memEn = en; o.memWr = wr;
    o.memAddr = ad; o.memWdata = wd;
    return o;
  endfunction

  function automatic outs_t sampleOuts();
    return mkOuts(ackA, rdataA, ackB, rdataB, stallA, busy, memEn, memWr, memAddr, memWdata);
  endfunction

  task automatic applyStimulus(input logic rA, input logic wA, input logic [AW-1:0] aA,
                               input logic [DW-1:0] dA, input logic rB, input logic wB,
                               input logic [AW-1:0] aB, input logic [DW-1:0] dB);
    @(posedge clk);
    #1;
    reqA = rA; weA = wA; addrA = aA; wdataA = dA;
    reqB = rB; weB = wB; addrB = aB; wdataB = dB;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t got;
    got = sampleOuts();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    reqA = 1'b0; weA = 1'b0; addrA = '0; wdataA = '0;
    reqB = 1'b0; weB = 1'b0; addrB = '0; wdataB = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vec_t vecs [10];
    int   ackAc, ackBc;
    logic [DW-1:0] rdSeen;
    // random-phase requester and model state
    logic          pA, pB, wA, wB;
    logic [AW-1:0] aA, aB;
    logic [DW-1:0] dA, dB;
    int            freeAt, ackAt;
    logic          lastB, ownB, isIdle, gWe;
    logic [AW-1:0] gAddr;
    logic [DW-1:0] expRd;
    logic [19:0]   expPack, gotPack;
    logic          eAckA, eAckB;

    for (int i = 0; i < 32; i++) benchMem[i] = initVal(i);
    benchMem[3] = 8'hA5;

    // Per-cycle vectors: a read of address 3 by A, a write of address 7 by B,
    // then an A read of address 7 that must return B's data.
    vecs[0] = '{1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00,
                mkOuts(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00)};
    vecs[1] = '{1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00,
                mkOuts(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 8'h00)};
    vecs[2] = '{1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00,
                mkOuts(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00)};
    vecs[3] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd7, 8'h3C,
                mkOuts(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00)};
    vecs[4] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd7, 8'h3C,
                mkOuts(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 8'h3C)};
    vecs[5] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd7, 8'h3C,
                mkOuts(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00)};
    vecs[6] = '{1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00,
                mkOuts(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00)};
    vecs[7] = '{1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00,
                mkOuts(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 8'h00)};
    vecs[8] = '{1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00,
                mkOuts(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00)};
    vecs[9] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00,
                mkOuts(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00)};

    // Reset state: every output is 0 and stall_a follows req_a.
    reset = 1'b0;
    reqA = 1'b1; weA = 1'b0; addrA = 5'd1; wdataA = 8'h00;
    reqB = 1'b1; weB = 1'b0; addrB = 5'd2; wdataB = 8'h00;
    @(negedge clk);
    checkOutput("reset outputs, req_a high",
                mkOuts(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00));
    reqA = 1'b0; reqB = 1'b0;
    #1;
    checkOutput("reset outputs, req_a low",
                mkOuts(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00));
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].reqA, vecs[i].weA, vecs[i].addrA, vecs[i].wdataA,
                    vecs[i].reqB, vecs[i].weB, vecs[i].addrB, vecs[i].wdataB);
      @(negedge clk);
      checkOutput($sformatf("vector %0d", i), vecs[i].exp);
    end

    // Contention straight after reset: A acks in cycles 2,8; B acks in cycles 5,11.
    $display("[TB] contention");
    doReset();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b0, 5'd1, 8'h00, 1'b1, 1'b0, 5'd2, 8'h00);
      @(negedge clk);
      checkValue($sformatf("contention acks c=%0d", c), int'({ackA, ackB}),
                 int'({(c % 6) == 2, (c % 6) == 5}));
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);

    // Late request: B rises during A's ACCESS cycle and is acked 3 cycles after A.
    $display("[TB] late request");
    ackAc = -1; ackBc = -1; rdSeen = '0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(ackAc < 0, 1'b0, 5'd3, 8'h00, (c >= 1) && (ackBc < 0), 1'b0, 5'd5, 8'h00);
      @(negedge clk);
      if (ackA && ackAc < 0) ackAc = c;
      if (ackB && ackBc < 0) begin ackBc = c; rdSeen = rdataB; end
    end
    checkValue("late ack_a cycle", ackAc, 2);
    checkValue("late ack_b after ack_a", ackBc - ackAc, 3);
    checkValue("late rdata_b", int'(rdSeen), int'(initVal(5)));

    // Reset abort during the ACCESS cycle of an A read.
    $display("[TB] reset abort");
    applyStimulus(1'b1, 1'b0, 5'd4, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 5'd4, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    checkValue("abort ack_a in reset", int'(ackA), 0);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    checkValue("abort ack_a held reset", int'(ackA), 0);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    checkValue("abort after release busy/mem_en/ack_a", int'({busy, memEn, ackA}), 0);
    ackAc = -1; rdSeen = '0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(ackAc < 0, 1'b0, 5'd4, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
      @(negedge clk);
      if (ackA && ackAc < 0) begin ackAc = c; rdSeen = rdataA; end
    end
    checkValue("reissue latency", ackAc, 2);
    checkValue("reissue rdata_a", int'(rdSeen), int'(initVal(4)));

    // Address change after capture must not reach the memory.
    $display("[TB] input change after capture");
    applyStimulus(1'b1, 1'b0, 5'd2, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    checkValue("captured mem_addr", int'(memAddr), 2);
    applyStimulus(1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    checkValue("captured ack_a", int'(ackA), 1);
    checkValue("captured rdata_a", int'(rdataA), int'(initVal(2)));
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);

    // Random traffic from two requesters. The model schedules transactions:
    // a free arbiter with pending requests grants round-robin, the ack follows
    // 2 cycles later, and the arbiter is free again 3 cycles after the grant.
    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 32; i++) goldMem[i] = benchMem[i];
    pA = 1'b0; pB = 1'b0; wA = 1'b0; wB = 1'b0; aA = '0; aB = '0; dA = '0; dB = '0;
    freeAt = 0; ackAt = -1; lastB = 1'b1; ownB = 1'b0; expRd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pA && $urandom_range(0, 2) == 0) begin
        pA = 1'b1; wA = 1'($urandom_range(0, 1)); aA = AW'($urandom_range(0, 31)); dA = DW'($urandom);
      end
      if (!pB && $urandom_range(0, 2) == 0) begin
        pB = 1'b1; wB = 1'($urandom_range(0, 1)); aB = AW'($urandom_range(0, 31)); dB = DW'($urandom);
      end
      applyStimulus(pA, wA, aA, dA, pB, wB, aB, dB);

      isIdle = (c == freeAt);
      if (isIdle) begin
        if (pA || pB) begin
          ownB  = pB && (!pA || !lastB);
          lastB = ownB;
          gWe   = ownB ? wB : wA;
          gAddr = ownB ? aB : aA;
          expRd = gWe ? '0 : goldMem[gAddr];
          if (gWe) goldMem[gAddr] = ownB ? dB : dA;
          ackAt  = c + 2;
          freeAt = c + 3;
        end else begin
          freeAt = c + 1;
        end
      end

      @(negedge clk);
      eAckA   = (c == ackAt) && !ownB;
      eAckB   = (c == ackAt) && ownB;
      expPack = {eAckA, eAckA ? expRd : 8'h00, eAckB, eAckB ? expRd : 8'h00,
                 pA && !eAckA, !isIdle};
      gotPack = {ackA, rdataA, ackB, rdataB, stallA, busy};
      checkValue($sformatf("random c=%0d {ackA,rdA,ackB,rdB,stall,busy}", c),
                 int'(gotPack), int'(expPack));
      if (ackA) pA = 1'b0;
      if (ackB) pB = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous program/data memory of the VeriRISC core between two requesters.
- Port A is the CPU memory interface: instruction fetch and operand/STO traffic.
- Port B is the loader/debug interface: program download and memory inspection.
- Provides a req/ack handshake per port, round-robin arbitration, a fixed 3-cycle transaction and a CPU stall indication.

Parameters:
- ADDR_W, 5, memory address width
- DATA_W, 8, memory data width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_a  in  1  port A request
- we_a  in  1  port A write enable (1=write, 0=read)
- addr_a  in  ADDR_W  port A address
- wdata_a  in  DATA_W  port A write data
- ack_a  out  1  port A transaction complete
- rdata_a  out  DATA_W  port A read data, valid while ack_a=1
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b  as for port A, for port B
- stall_a  out  1  req_a=1 and ack_a=0 (combinational); feeds the CPU controller clock-enable
- busy  out  1  FSM not in IDLE
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_wr=0

Behaviour:
- FSM states are IDLE, ACCESS and RESP.
  - Transitions: IDLE->ACCESS when any req is high; ACCESS->RESP always; RESP->IDLE always.
- IDLE, arbitration and capture:
  - Only A requesting: grant A. Only B requesting: grant B.
  - Both requesting: grant the port that is not last_owner.
  - On grant, register owner, we, addr and wdata of the granted port; set last_owner=owner.
- ACCESS:
  - mem_en=1, mem_wr=captured we, mem_addr=captured addr, mem_wdata=captured wdata.
- RESP:
  - ack_<owner>=1 for exactly one cycle.
  - rdata_<owner>=mem_rdata when captured we=0; rdata is 0 on writes.
  - The non-owner's ack and rdata stay 0.
- Latency and throughput:
  - req sampled high in IDLE at edge N gives ACCESS in cycle N+1 and ack in cycle N+2.
  - One transaction per 3 cycles.
- Handshake rules:
  - The requester holds req, we, addr and wdata until it sees ack.
  - It deasserts req on the edge that ends the ack cycle.
  - If req is still high in the following IDLE, that is a new transaction.
  - The arbiter ignores input changes after the capture edge.
- Fairness:
  - Back-to-back contention alternates A,B,A,B.
  - A port waits at most one transaction (3 cycles) plus its own.
- Outputs outside ACCESS/RESP:
  - mem_en=mem_wr=0; mem_addr, mem_wdata=0.
  - ack_*=0, rdata_*=0.
- Reset (asynchronous, active-low):
  - state=IDLE, last_owner=B (so A wins the first tie), all captured registers 0, all outputs 0 (stall_a follows req_a).
  - Reset mid-transaction aborts it: no ack is issued; a write in ACCESS may or may not have reached memory.
  - After reset release, requesters must re-request.
- A req rising during ACCESS/RESP is not lost; it is arbitrated in the next IDLE.
- Simultaneous req_a/req_b with equal addresses and both writes: serialized per round-robin; the later write wins in memory.

Test Plan:
- Single read: mem[3]=8'hA5, req_a=1, we_a=0, addr_a=3 at cycle 0 -> mem_en=1, mem_addr=3 in cycle 1; ack_a=1, rdata_a=8'hA5 in cycle 2; stall_a=1 in cycles 0-1 and 0 in cycle 2.
- Single write via B: req_b=1, we_b=1, addr_b=7, wdata_b=8'h3C -> cycle 1 mem_en=mem_wr=1, mem_addr=7, mem_wdata=8'h3C; cycle 2 ack_b=1, rdata_b=0; a subsequent A read of address 7 returns 8'h3C.
- Contention after reset: req_a and req_b held high continuously -> grant order A,B,A,B; ack_a in cycles 2 and 8, ack_b in cycles 5 and 11; acks are never simultaneous.
- Late request: req_b rises during A's ACCESS cycle -> B is granted in the next IDLE, and B's ack follows A's ack by exactly 3 cycles.
- Reset abort: assert reset during ACCESS of an A read -> ack_a is never asserted; after release busy=0 and mem_en=0; a re-issued req_a completes normally with 3-cycle latency.
- Input change after capture: change addr_a from 2 to 9 during ACCESS -> mem_addr stays 2 and rdata_a returns mem[2].
